// File: rtl/user_pkg.sv
// Shared types and constants for the user ID check block.
// Holds the ID width, the empty-slot marker and the FSM encoding.
package user_pkg;

    localparam int ID_W = 16;

    localparam logic [ID_W-1:0] EMPTY_ID = 16'h0000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEARCH = 3'd1,
        GRANT  = 3'd2,
        DENY   = 3'd3,
        LOCK   = 3'd4
    } state_t;

    // Index width for a table of n slots; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width that can hold the values 0..max_fail inclusive.
    function automatic int fc_width(input int max_fail);
        return (max_fail > 0) ? $clog2(max_fail + 1) : 1;
    endfunction

endpackage

// File: rtl/user_id_rom.sv
// Combinational slot selector over the packed table of registered IDs.
// Slot 0 sits in the most significant 16 bits of the table.
module user_id_rom
    import user_pkg::*;
#(
    parameter int                     NUM_IDS  = 4,
    parameter logic [NUM_IDS*ID_W-1:0] ID_TABLE = 64'h1234_ABCD_0000_0042,
    localparam int                    IDX_W    = idx_width(NUM_IDS)
) (
    input  logic [IDX_W-1:0] idx,
    output logic [ID_W-1:0]  slot,
    output logic             slot_used
);

    // Pick the addressed slot; indices beyond the table read as empty.
    always_comb begin
        slot = EMPTY_ID;
        for (int k = 0; k < NUM_IDS; k++) begin
            if (idx == IDX_W'(k)) begin
                slot = ID_TABLE[ID_W*(NUM_IDS-k)-1 -: ID_W];
            end
        end
    end

    // An all-zero slot is unpopulated and must never produce a match.
    assign slot_used = (slot != EMPTY_ID);

endmodule

// File: rtl/user_id_check.sv
// Searches the registered-ID table for the entered ID, one slot per cycle,
// and issues grant/deny with a consecutive-denial lockout.
module user_id_check
    import user_pkg::*;
#(
    parameter int                     NUM_IDS  = 4,
    parameter logic [NUM_IDS*ID_W-1:0] ID_TABLE = 64'h1234_ABCD_0000_0042,
    parameter int                     MAX_FAIL = 3,
    localparam int                    IDX_W    = idx_width(NUM_IDS),
    localparam int                    FC_W     = fc_width(MAX_FAIL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [ID_W-1:0]  id_in,
    input  logic             retry,
    input  logic             unlock,
    output logic             busy,
    output logic             auth_grant,
    output logic             auth_deny,
    output logic             locked,
    output logic [IDX_W-1:0] match_index,
    output logic [FC_W-1:0]  fail_count
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IDS - 1);
    localparam logic [FC_W-1:0]  FC_MAX   = FC_W'(MAX_FAIL);

    state_t           state;
    state_t           state_d;
    logic             id_valid_q;
    logic [ID_W-1:0]  id_reg;
    logic [ID_W-1:0]  id_reg_d;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_d;
    logic [IDX_W-1:0] match_index_d;
    logic [FC_W-1:0]  fail_count_d;
    logic [FC_W-1:0]  fc_inc;
    logic [ID_W-1:0]  slot;
    logic             slot_used;
    logic             start;
    logic             hit;

    user_id_rom #(
        .NUM_IDS  (NUM_IDS),
        .ID_TABLE (ID_TABLE)
    ) u_rom (
        .idx       (idx),
        .slot      (slot),
        .slot_used (slot_used)
    );

    // Only a rising edge of the level-valid flag starts a search.
    assign start = id_valid & ~id_valid_q;

    assign hit = slot_used && (slot == id_reg);

    // Denial count saturates so repeated denials cannot wrap it.
    assign fc_inc = (fail_count == FC_MAX) ? fail_count
                                           : fail_count + FC_W'(1);

    // Next-state and next-register values for the search FSM.
    always_comb begin
        state_d       = state;
        id_reg_d      = id_reg;
        idx_d         = idx;
        match_index_d = match_index;
        fail_count_d  = fail_count;
        unique case (state)
            IDLE: begin
                if (start) begin
                    id_reg_d = id_in;
                    idx_d    = '0;
                    state_d  = SEARCH;
                end
            end
            SEARCH: begin
                if (hit) begin
                    match_index_d = idx;
                    fail_count_d  = '0;
                    state_d       = GRANT;
                end else if (idx == LAST_IDX) begin
                    fail_count_d = fc_inc;
                    state_d      = (fc_inc == FC_MAX) ? LOCK : DENY;
                end else begin
                    idx_d = idx + IDX_W'(1);
                end
            end
            GRANT: begin
                if (retry) begin
                    state_d = IDLE;
                end
            end
            DENY: begin
                // Supervisor release wins and also clears the history.
                if (unlock) begin
                    fail_count_d = '0;
                    state_d      = IDLE;
                end else if (retry) begin
                    state_d = IDLE;
                end
            end
            LOCK: begin
                if (unlock) begin
                    fail_count_d = '0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            id_valid_q  <= 1'b0;
            id_reg      <= '0;
            idx         <= '0;
            match_index <= '0;
            fail_count  <= '0;
        end else begin
            state       <= state_d;
            id_valid_q  <= id_valid;
            id_reg      <= id_reg_d;
            idx         <= idx_d;
            match_index <= match_index_d;
            fail_count  <= fail_count_d;
        end
    end

    // Status flags are pure decodes of the state register.
    always_comb begin
        busy       = (state == SEARCH);
        auth_grant = (state == GRANT);
        auth_deny  = (state == DENY) || (state == LOCK);
        locked     = (state == LOCK);
    end

endmodule
